// File: rtl/rvfi_dii_fetch_buffer.sv
// RVFI-DII fetch injector: serves frontend fetches from a DEPTH-entry instruction FIFO filled by Vengine,
// with same-cycle bypass when empty. Optional `RVFI_DII_FETCH_STATS_EN adds served/killed counters.

package rvfi_dii_fetch_buffer_pkg;
  typedef struct packed {
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32};
  localparam int unsigned VLEN = 32;

  typedef struct packed {
    logic [31:0]     cause;
    logic [VLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic            req;
    logic            kill_s1;
    logic            kill_s2;
    logic [VLEN-1:0] vaddr;
    exception_t      ex;
  } icache_dreq_t;

  typedef struct packed {
    logic            ready;
    logic            valid;
    logic [31:0]     data;
    logic [VLEN-1:0] vaddr;
    exception_t      ex;
  } icache_drsp_t;

  typedef struct packed {
    logic [31:0] rvfi_insn;
  } rvfi_dii_inst_pack_t;
endpackage

module rvfi_dii_fetch_buffer #(
  parameter rvfi_dii_fetch_buffer_pkg::cva6_cfg_t CVA6Cfg = rvfi_dii_fetch_buffer_pkg::cva6_cfg_empty,
  parameter int unsigned DEPTH = 4,
  parameter type icache_dreq_t        = rvfi_dii_fetch_buffer_pkg::icache_dreq_t,
  parameter type icache_drsp_t        = rvfi_dii_fetch_buffer_pkg::icache_drsp_t,
  parameter type exception_t          = rvfi_dii_fetch_buffer_pkg::exception_t,
  parameter type rvfi_dii_inst_pack_t = rvfi_dii_fetch_buffer_pkg::rvfi_dii_inst_pack_t
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  icache_dreq_t                dreq_i,
  output icache_drsp_t                dreq_o,
  input  logic                        rvfi_dii_rtrn_vld_i,
  input  rvfi_dii_inst_pack_t         rvfi_dii_inst_pack_i,
  output logic                        rvfi_dii_data_ready_o,
`ifdef RVFI_DII_FETCH_STATS_EN
  output logic [31:0]                 stat_served_o,
  output logic [31:0]                 stat_killed_o,
`endif
  output logic [$clog2(DEPTH):0]      fifo_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned VW    = CVA6Cfg.VLEN;

  typedef enum logic {IDLE, BUSY} state_e;

  // Handshakes: Vengine push happens when rvfi_dii_rtrn_vld_i & rvfi_dii_data_ready_o;
  // a fetch request is taken when dreq_i.req & dreq_o.ready; a response is dreq_o.valid for one cycle.
  state_e              state_q;
  logic [VW-1:0]       vaddr_q;
  exception_t          ex_q;
  logic [31:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic kill, in_busy, has_data, serve, pop, bypass, push_ready, push_store;

  assign kill       = dreq_i.kill_s1 | dreq_i.kill_s2;
  assign in_busy    = (state_q == BUSY);
  assign has_data   = (count_q != '0);
  assign serve      = in_busy & ~kill & ~flush_i & (has_data | rvfi_dii_rtrn_vld_i);
  assign pop        = serve & has_data;
  assign bypass     = serve & ~has_data;
  // A full FIFO still accepts a push in the cycle its head is popped.
  assign push_ready = ~flush_i & ((count_q < CNT_W'(DEPTH)) | pop);
  assign push_store = rvfi_dii_rtrn_vld_i & push_ready & ~bypass;

  assign rvfi_dii_data_ready_o = push_ready;
  assign fifo_count_o          = count_q;

  always_comb begin
    dreq_o       = '0;
    dreq_o.ready = ~in_busy;
    dreq_o.valid = serve;
    dreq_o.data  = has_data ? mem_q[rd_ptr_q] : rvfi_dii_inst_pack_i.rvfi_insn;
    dreq_o.vaddr = vaddr_q;
    dreq_o.ex    = ex_q;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)        rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_store) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_store) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_store) mem_q[wr_ptr_q] <= rvfi_dii_inst_pack_i.rvfi_insn;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      vaddr_q  <= '0;
      ex_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (flush_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (dreq_i.req && !kill) begin
              state_q <= BUSY;
              vaddr_q <= dreq_i.vaddr;
              ex_q    <= dreq_i.ex;
            end
          end
          BUSY: begin
            // A kill or a delivered response both end the fetch.
            if (kill || serve) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef RVFI_DII_FETCH_STATS_EN
  logic [31:0] served_q, killed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      served_q <= '0;
      killed_q <= '0;
    end else if (flush_i) begin
      served_q <= '0;
      killed_q <= '0;
    end else begin
      if (serve)          served_q <= served_q + 32'd1;
      if (in_busy && kill) killed_q <= killed_q + 32'd1;
    end
  end

  assign stat_served_o = served_q;
  assign stat_killed_o = killed_q;
`endif

endmodule

// File: tb/tb_rvfi_dii_fetch_buffer.sv
// Bench for rvfi_dii_fetch_buffer: directed scenarios then random traffic, checked each cycle
// against a queue-based reference of the injector's fetch/push rules.
module tb_rvfi_dii_fetch_buffer;
  import rvfi_dii_fetch_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  icache_dreq_t        dreq_i;
  icache_drsp_t        dreq_o;
  logic                vld;
  rvfi_dii_inst_pack_t pack;
  logic                data_ready;
  logic [2:0]          count;
`ifdef RVFI_DII_FETCH_STATS_EN
  logic [31:0]         stat_served, stat_killed;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference state: pending instructions in order, and the outstanding fetch.
  logic [31:0] exp_q[$];
  logic        m_busy = 1'b0;
  logic [31:0] m_vaddr = '0;
  exception_t  m_ex = '0;
  int          m_served = 0;
  int          m_killed = 0;

  rvfi_dii_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .flush_i               (flush),
    .dreq_i                (dreq_i),
    .dreq_o                (dreq_o),
    .rvfi_dii_rtrn_vld_i   (vld),
    .rvfi_dii_inst_pack_i  (pack),
    .rvfi_dii_data_ready_o (data_ready),
`ifdef RVFI_DII_FETCH_STATS_EN
    .stat_served_o         (stat_served),
    .stat_killed_o         (stat_killed),
`endif
    .fifo_count_o          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    flush  = 1'b0;
    dreq_i = '0;
    vld    = 1'b0;
    pack   = '0;
  endtask

  task automatic push(input logic [31:0] insn);
    vld            = 1'b1;
    pack.rvfi_insn = insn;
  endtask

  task automatic req(input logic [31:0] va);
    dreq_i.req   = 1'b1;
    dreq_i.vaddr = va;
    dreq_i.ex    = '{cause: va ^ 32'h5a5a_0000, tval: va, valid: va[0]};
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_busy   = 1'b0;
    m_served = 0;
    m_killed = 0;
  endtask

  // Check outputs mid-cycle against the reference, then advance the reference by one clock.
  task automatic model_step();
    int   sz;
    logic k, e_valid, e_prdy, byp;
    sz      = exp_q.size();
    k       = dreq_i.kill_s1 | dreq_i.kill_s2;
    e_valid = !flush && m_busy && !k && (sz > 0 || vld);
    e_prdy  = !flush && (sz < DEPTH || (e_valid && sz > 0));
    chk("count", count, sz);
    chk("req_ready", dreq_o.ready, !m_busy);
    chk("push_ready", data_ready, e_prdy);
    chk("valid", dreq_o.valid, e_valid);
    if (e_valid) begin
      chk("data", dreq_o.data, (sz > 0) ? exp_q[0] : pack.rvfi_insn);
      chk("vaddr", dreq_o.vaddr, m_vaddr);
      chk("ex", dreq_o.ex, m_ex);
    end
`ifdef RVFI_DII_FETCH_STATS_EN
    chk("stat_served", stat_served, m_served);
    chk("stat_killed", stat_killed, m_killed);
`endif
    if (flush) begin
      model_clear();
    end else begin
      byp = e_valid && sz == 0;
      if (e_valid) m_served++;
      if (m_busy && k) m_killed++;
      if (e_valid && sz > 0) void'(exp_q.pop_front());
      if (vld && e_prdy && !byp) exp_q.push_back(pack.rvfi_insn);
      if (!m_busy) begin
        if (dreq_i.req && !k) begin
          m_busy  = 1'b1;
          m_vaddr = dreq_i.vaddr;
          m_ex    = dreq_i.ex;
        end
      end else if (k || e_valid) begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    #1;
    chk("rst_count", count, 0);
    chk("rst_req_ready", dreq_o.ready, 1);
    chk("rst_push_ready", data_ready, 1);
    chk("rst_valid", dreq_o.valid, 0);
    tick();

    // Bypass: request with empty FIFO, instruction arrives two cycles later
    req(32'h8000_0000); tick();
    set_idle(); tick();
    push(32'h0000_0013);
    #1;
    chk("byp_valid", dreq_o.valid, 1);
    chk("byp_data", dreq_o.data, 32'h13);
    chk("byp_vaddr", dreq_o.vaddr, 32'h8000_0000);
    tick();
    set_idle();
    chk("byp_count", count, 0);
    tick();

    // Fill to DEPTH, hold a fifth push, then pop and push in the same cycle
    for (int i = 0; i < DEPTH; i++) begin
      push(32'h1000_0000 + i); tick();
    end
    set_idle(); #1;
    chk("full_count", count, 4);
    chk("full_push_ready", data_ready, 0);
    push(32'h1000_0004); tick();
    req(32'h8000_0100); tick();
    dreq_i = '0; tick();
    set_idle();
    chk("full_popush_count", count, 4);
    for (int i = 0; i < DEPTH; i++) begin
      req(32'h8000_0200 + 4 * i); tick();
      set_idle(); tick();
    end

    // Kill in BUSY does not consume the preloaded instruction
    push(32'hAAAA_0001); tick();
    set_idle(); req(32'h8000_0300); tick();
    set_idle(); dreq_i.kill_s2 = 1'b1; tick();
    set_idle();
    chk("kill_count", count, 1);
    req(32'h8000_0304); tick();
    set_idle(); #1;
    chk("kill_next_data", dreq_o.data, 32'hAAAA_0001);
    chk("kill_next_valid", dreq_o.valid, 1);
    tick();

    // Request together with kill_s1 in IDLE is ignored
    req(32'h0000_1234); dreq_i.kill_s1 = 1'b1; tick();
    set_idle(); #1;
    chk("idle_kill_ready", dreq_o.ready, 1);
    tick();

    // Flush while BUSY with three entries
    for (int i = 0; i < 3; i++) begin
      push(32'h2000_0000 + i); tick();
    end
    set_idle(); req(32'h8000_0400); tick();
    set_idle(); flush = 1'b1; tick();
    set_idle();
    chk("flush_count", count, 0);
    chk("flush_req_ready", dreq_o.ready, 1);
    repeat (3) tick();

`ifdef RVFI_DII_FETCH_STATS_EN
    flush = 1'b1; tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      push(32'h3000_0000 + i); tick();
      set_idle(); req(32'h8000_0500); tick();
      set_idle(); tick();
    end
    for (int i = 0; i < 2; i++) begin
      req(32'h8000_0600); tick();
      set_idle(); dreq_i.kill_s1 = 1'b1; tick();
      set_idle();
    end
    chk("stat_served_3", stat_served, 3);
    chk("stat_killed_2", stat_killed, 2);
    flush = 1'b1; tick();
    set_idle();
    chk("stat_served_flush", stat_served, 0);
    chk("stat_killed_flush", stat_killed, 0);
`endif

    // Randomized traffic, alternating push-heavy and fetch-heavy phases
    for (int i = 0; i < 600; i++) begin
      logic push_heavy;
      push_heavy     = ((i / 50) % 2) == 0;
      flush          = ($urandom_range(0, 59) == 0);
      dreq_i.req     = push_heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      dreq_i.kill_s1 = ($urandom_range(0, 11) == 0);
      dreq_i.kill_s2 = ($urandom_range(0, 11) == 0);
      dreq_i.vaddr   = $urandom;
      dreq_i.ex      = '{cause: $urandom, tval: $urandom, valid: 1'($urandom)};
      vld            = push_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      pack.rvfi_insn = $urandom;
      tick();
    end
    set_idle();

    // Asynchronous reset in the middle of a fetch
    push(32'h4000_0000); tick();
    push(32'h4000_0001); tick();
    set_idle(); req(32'h8000_0700); tick();
    set_idle();
    rst_n = 1'b0;
    #1;
    chk("areset_count", count, 0);
    chk("areset_req_ready", dreq_o.ready, 1);
    chk("areset_valid", dreq_o.valid, 0);
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
